// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the multi-port register scoreboard.
// Holds the flush FSM encoding and the special register indices.
package scoreboard_pkg;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_DRAIN = 2'd1,
    SB_DONE  = 2'd2
  } sb_flush_state_t;

  localparam int REG_CR = 32;
  localparam int REG_PR = 33;

endpackage

// File: rtl/scoreboard_mp_if.sv
// Bundle of the reserve, query, release and flush signals of scoreboard_mp.
// The master drives requests; the slave (the scoreboard) answers.
interface scoreboard_mp_if #(
  parameter int NUM_TID  = 256,
  parameter int NUM_REGS = 34,
  parameter int NUM_WB   = 2
);
  localparam int TID_W = $clog2(NUM_TID);
  localparam int REG_W = $clog2(NUM_REGS);

  logic                               rsv_valid;
  logic                               rsv_ready;
  logic [TID_W-1:0]                   rsv_tid;
  logic [NUM_REGS-1:0]                rsv_map;

  logic                               rd_valid;
  logic [TID_W-1:0]                   rd_tid;
  logic [NUM_REGS-1:0]                rd_map;
  logic                               collision;

  logic [NUM_WB-1:0]                  wb_valid;
  logic [NUM_WB-1:0][NUM_TID-1:0]     wb_tid_bitmap;
  logic [NUM_WB-1:0][REG_W-1:0]       wb_reg;

  logic                               flush_req;
  logic                               flush_done;
  logic                               busy;

  modport master (
    output rsv_valid, rsv_tid, rsv_map,
    output rd_valid, rd_tid, rd_map,
    output wb_valid, wb_tid_bitmap, wb_reg,
    output flush_req,
    input  rsv_ready, collision, flush_done, busy
  );

  modport slave (
    input  rsv_valid, rsv_tid, rsv_map,
    input  rd_valid, rd_tid, rd_map,
    input  wb_valid, wb_tid_bitmap, wb_reg,
    input  flush_req,
    output rsv_ready, collision, flush_done, busy
  );

endinterface

// File: rtl/scoreboard_mp_entry.sv
// Pending-register vector for one thread ID.
// Set has priority over clear so a same-cycle reserve survives a release.
module scoreboard_mp_entry #(
  parameter int NUM_REGS = 34
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REGS-1:0] set_mask,
  input  logic [NUM_REGS-1:0] clr_mask,
  output logic [NUM_REGS-1:0] pend
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/scoreboard_mp.sv
// Multi-port register scoreboard: per-TID pending bits, reserve/release,
// combinational collision query and a flush/drain FSM.
// Optional build macro SCOREBOARD_STATS_EN adds a saturating stall_cnt output.
module scoreboard_mp
  import scoreboard_pkg::*;
#(
  parameter int NUM_TID  = 256,
  parameter int NUM_REGS = 34,
  parameter int NUM_WB   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  scoreboard_mp_if.slave    sb
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int TID_W = $clog2(NUM_TID);
  localparam int REG_W = $clog2(NUM_REGS);

  sb_flush_state_t     state;
  logic                idle_q;
  logic                flush_done_q;
  logic                rsv_fire;
  logic                busy_int;
  logic                collision_int;
  logic                hit_a;
  logic                hit_b;
  logic                hit_c;
  logic [NUM_REGS-1:0] pend   [NUM_TID];
  logic [NUM_REGS-1:0] wb_dec [NUM_WB];

  assign sb.rsv_ready  = idle_q & ~sb.flush_req;
  assign rsv_fire      = sb.rsv_valid & sb.rsv_ready;
  assign sb.flush_done = flush_done_q;
  assign sb.busy       = busy_int;
  assign sb.collision  = collision_int;

  // One-hot clear pattern per release port; out-of-range indices drop out here
  always_comb begin
    for (int p = 0; p < NUM_WB; p++) begin
      wb_dec[p] = '0;
      if (sb.wb_valid[p] && (int'(sb.wb_reg[p]) < NUM_REGS)) begin
        wb_dec[p][sb.wb_reg[p]] = 1'b1;
      end
    end
  end

  for (genvar j = 0; j < NUM_TID; j++) begin : g_entry
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    always_comb begin
      set_mask = (rsv_fire && (sb.rsv_tid == TID_W'(j))) ? sb.rsv_map : '0;
      clr_mask = '0;
      for (int p = 0; p < NUM_WB; p++) begin
        if (sb.wb_tid_bitmap[p][j]) begin
          clr_mask = clr_mask | wb_dec[p];
        end
      end
    end

    scoreboard_mp_entry #(
      .NUM_REGS (NUM_REGS)
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_mask (set_mask),
      .clr_mask (clr_mask),
      .pend     (pend[j])
    );
  end

  always_comb begin
    busy_int = 1'b0;
    for (int j = 0; j < NUM_TID; j++) begin
      busy_int = busy_int | (|pend[j]);
    end
  end

  // Any in-flight release to the queried TID counts as a hit, whatever register it frees
  always_comb begin
    hit_a = |(pend[sb.rd_tid] & sb.rd_map);
    hit_b = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      hit_b = hit_b | (sb.wb_valid[p] & sb.wb_tid_bitmap[p][sb.rd_tid]);
    end
    hit_c = rsv_fire && (sb.rsv_tid == sb.rd_tid) && (|(sb.rsv_map & sb.rd_map));
    collision_int = sb.rd_valid & (hit_a | hit_b | hit_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SB_IDLE;
      idle_q       <= 1'b1;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state)
        SB_IDLE: begin
          if (sb.flush_req) begin
            state  <= SB_DRAIN;
            idle_q <= 1'b0;
          end
        end
        SB_DRAIN: begin
          if (!busy_int) begin
            state        <= SB_DONE;
            flush_done_q <= 1'b1;
          end
        end
        SB_DONE: begin
          state  <= SB_IDLE;
          idle_q <= 1'b1;
        end
        default: begin
          state  <= SB_IDLE;
          idle_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (collision_int && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_scoreboard_mp.sv
// Directed bench for scoreboard_mp: stimulus queues expectations, a negedge
// monitor pops and compares them. Covers stall_cnt when SCOREBOARD_STATS_EN is set.
module tb_scoreboard_mp;
  localparam int NUM_TID  = 256;
  localparam int NUM_REGS = 34;
  localparam int NUM_WB   = 2;
  localparam int TID_W    = $clog2(NUM_TID);
  localparam int REG_W    = $clog2(NUM_REGS);

  localparam int K_COLL  = 0;
  localparam int K_BUSY  = 1;
  localparam int K_RDY   = 2;
  localparam int K_DONE  = 3;
  localparam int K_STALL = 4;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t q[$];

  scoreboard_mp_if #(.NUM_TID(NUM_TID), .NUM_REGS(NUM_REGS), .NUM_WB(NUM_WB)) sb ();

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  scoreboard_mp #(
    .NUM_TID  (NUM_TID),
    .NUM_REGS (NUM_REGS),
    .NUM_WB   (NUM_WB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sb        (sb)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        K_COLL:  act = {31'd0, sb.collision};
        K_BUSY:  act = {31'd0, sb.busy};
        K_RDY:   act = {31'd0, sb.rsv_ready};
        K_DONE:  act = {31'd0, sb.flush_done};
`ifdef SCOREBOARD_STATS_EN
        K_STALL: act = stall_cnt;
`endif
        default: act = 32'hDEAD_BEEF;
      endcase
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
      end
    end
  end

  task automatic clear_in();
    sb.rsv_valid     = 1'b0;
    sb.rsv_tid       = '0;
    sb.rsv_map       = '0;
    sb.rd_valid      = 1'b0;
    sb.rd_tid        = '0;
    sb.rd_map        = '0;
    sb.wb_valid      = '0;
    sb.wb_tid_bitmap = '0;
    sb.wb_reg        = '0;
    sb.flush_req     = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic reserve(input int tid, input logic [NUM_REGS-1:0] map);
    sb.rsv_valid = 1'b1;
    sb.rsv_tid   = TID_W'(tid);
    sb.rsv_map   = map;
  endtask

  task automatic query(input int tid, input logic [NUM_REGS-1:0] map);
    sb.rd_valid = 1'b1;
    sb.rd_tid   = TID_W'(tid);
    sb.rd_map   = map;
  endtask

  task automatic rel(input int p, input int tid, input int r);
    sb.wb_valid[p]           = 1'b1;
    sb.wb_tid_bitmap[p]      = '0;
    sb.wb_tid_bitmap[p][tid] = 1'b1;
    sb.wb_reg[p]             = REG_W'(r);
  endtask

  initial begin
    logic [NUM_REGS-1:0] all_ones;
    all_ones = '1;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    clear_in();

    // reset values
    step();
    chk(K_BUSY, 0, "rst_busy");
    chk(K_RDY,  1, "rst_ready");
    chk(K_DONE, 0, "rst_done");
    chk(K_COLL, 0, "rst_coll");
`ifdef SCOREBOARD_STATS_EN
    chk(K_STALL, 0, "rst_stall");
`endif
    step();
    rst_n = 1'b1;

    // statistics: ten collision cycles
    step();
    reserve(10, 34'h1);
    chk(K_RDY, 1, "stat_rsv_ready");
    for (int i = 0; i < 10; i++) begin
      step();
      query(10, 34'h1);
      chk(K_COLL, 1, "stat_coll");
`ifdef SCOREBOARD_STATS_EN
      if (i == 0) chk(K_STALL, 0, "stall_cnt_start");
`endif
    end
    step();
    rel(0, 10, 0);
    chk(K_COLL, 0, "stat_coll_off");
`ifdef SCOREBOARD_STATS_EN
    chk(K_STALL, 10, "stall_cnt_10");
`endif
    step();
    chk(K_BUSY, 0, "stat_cleanup_busy");

    // reserve then query, plus same-cycle reserve bypass
    step();
    reserve(5, 34'h3);
    query(5, 34'h1);
    chk(K_COLL, 1, "rsv_bypass");
    step();
    query(5, 34'h2);
    chk(K_COLL, 1, "query_hit");
    chk(K_BUSY, 1, "busy_set");
    step();
    query(5, 34'h4);
    chk(K_COLL, 0, "query_miss");
    step();
    rel(0, 5, 0);
    rel(1, 5, 1);
    step();
    query(5, 34'h3);
    chk(K_COLL, 0, "tid5_clear");
    chk(K_BUSY, 0, "tid5_busy");

    // dual release on different registers
    step();
    reserve(7, (34'h1 << 3) | (34'h1 << 9));
    step();
    rel(0, 7, 3);
    rel(1, 7, 9);
    query(7, 34'h1);
    chk(K_COLL, 1, "release_cycle_coll");
    step();
    query(7, all_ones);
    chk(K_COLL, 0, "tid7_clear");
    chk(K_BUSY, 0, "tid7_busy");

    // both ports clearing the same bit, and an untouched neighbour
    step();
    reserve(6, (34'h1 << 2) | (34'h1 << REG_W'(33)));
    step();
    rel(0, 6, 2);
    rel(1, 6, 2);
    step();
    query(6, 34'h1 << 2);
    chk(K_COLL, 0, "same_bit_clear");
    step();
    query(6, 34'h1 << 33);
    chk(K_COLL, 1, "pr_kept");
    step();
    rel(0, 6, 33);

    // set wins over same-cycle release
    step();
    reserve(2, 34'h1 << 4);
    rel(0, 2, 4);
    step();
    query(2, 34'h1 << 4);
    chk(K_COLL, 1, "set_wins");
    step();
    rel(0, 2, 4);
    step();
    query(2, 34'h1 << 4);
    chk(K_COLL, 0, "set_wins_cleanup");

    // out-of-range release ignored for that port only
    step();
    reserve(3, 34'h1 << 8);
    step();
    rel(0, 3, 40);
    step();
    query(3, 34'h1 << 8);
    chk(K_COLL, 1, "oor_ignored");
    step();
    rel(0, 3, 40);
    rel(1, 3, 8);
    step();
    query(3, all_ones);
    chk(K_COLL, 0, "oor_other_port");
    chk(K_BUSY, 0, "oor_busy");

    // flush drain with a late release
    step();
    reserve(1, 34'h1);
    step();
    sb.flush_req = 1'b1;
    chk(K_RDY,  0, "flush_req_ready");
    chk(K_BUSY, 1, "flush_busy0");
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 3) sb.flush_req = 1'b1;
      if (k == 5) rel(0, 1, 0);
      chk(K_RDY,  (k >= 8) ? 32'd1 : 32'd0, "drain_ready");
      chk(K_DONE, (k == 7) ? 32'd1 : 32'd0, "drain_done");
      chk(K_BUSY, (k <= 5) ? 32'd1 : 32'd0, "drain_busy");
    end

    // flush while already empty
    step();
    sb.flush_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk(K_DONE, (k == 2) ? 32'd1 : 32'd0, "empty_done");
      chk(K_RDY,  (k == 3) ? 32'd1 : 32'd0, "empty_ready");
    end

    // reset in the middle of DRAIN
    step();
    reserve(9, 34'h2);
    step();
    sb.flush_req = 1'b1;
    step();
    step();
    chk(K_DONE, 0, "mid_drain_done");
    chk(K_RDY,  0, "mid_drain_ready");
    step();
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (sb.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst_busy: got %0b expected 0", sb.busy);
    end
    n_tests++;
    if (sb.rsv_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_rst_ready: got %0b expected 1", sb.rsv_ready);
    end
    n_tests++;
    if (sb.flush_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst_done: got %0b expected 0", sb.flush_done);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) begin
        query(9, 34'h2);
        chk(K_COLL, 0, "rst_cleared_tid9");
      end
      chk(K_DONE, 0, "no_done_after_rst");
      chk(K_RDY,  1, "idle_after_rst");
    end

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    if (n_fail == 0) begin
      $display("PASS");
    end else begin
      $display("FAIL %0d checks", n_fail);
    end
    $finish;
  end

endmodule

// File: doc/scoreboard_mp.md
SCOREBOARD_MP -- requirements
Module: scoreboard_mp

Interface
REQ-001 SHALL have parameter NUM_TID, default 256, the number of thread IDs tracked.
REQ-002 SHALL have parameter NUM_REGS, default 34, the registers per TID (0-31 GPR, 32 CR, 33 PR).
REQ-003 SHALL have parameter NUM_WB, default 2, the number of independent write-back release ports.
REQ-004 SHALL define local widths TID_W = $clog2(NUM_TID) and REG_W = $clog2(NUM_REGS).
REQ-005 SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have ports rsv_valid, input, 1 bit, and rsv_ready, output, 1 bit: reserve handshake; a reserve fires when both are high.
REQ-008 SHALL have ports rsv_tid, input, TID_W, and rsv_map, input, NUM_REGS: the TID and the registers to mark pending.
REQ-009 SHALL have ports rd_valid, input, 1 bit; rd_tid, input, TID_W; rd_map, input, NUM_REGS: the collision query.
REQ-010 SHALL have port collision, output, 1 bit: combinational query result.
REQ-011 SHALL have ports wb_valid, input, NUM_WB bits; wb_tid_bitmap, input, [NUM_WB][NUM_TID]; wb_reg, input, [NUM_WB][REG_W]: the release ports.
REQ-012 SHALL have ports flush_req, input, 1 bit, and flush_done, output, 1 bit: the drain handshake.
REQ-013 SHALL have port busy, output, 1 bit: high when any pending bit is set in any entry.

Function
REQ-014 SHALL hold one NUM_REGS-bit pending vector per TID.
REQ-015 SHALL set every bit of rsv_map in entry rsv_tid on a reserve fire.
REQ-016 SHALL clear bit wb_reg[p] in every entry j where wb_valid[p] and wb_tid_bitmap[p][j] are both high, for each port p.
REQ-017 SHALL let multiple ports clearing the same bit in the same cycle act as a single clear.
REQ-018 SHALL ignore, for that port only, any wb_reg[p] value >= NUM_REGS.
REQ-019 SHALL, when a reserve and a release hit the same TID in the same cycle, set the bits in rsv_map and clear only the released bits not in rsv_map (set wins).
REQ-020 SHALL drive collision = rd_valid & (A | B | C), where:
  - A = any bit of (entry[rd_tid] & rd_map) is set;
  - B = any p has wb_valid[p] & wb_tid_bitmap[p][rd_tid] (conservative);
  - C = a reserve fires with rsv_tid == rd_tid and (rsv_map & rd_map) nonzero.
REQ-021 SHALL make state updates visible on collision one cycle after the update edge.
REQ-022 SHALL implement a flush FSM with states IDLE, DRAIN and DONE.
REQ-023 SHALL move IDLE -> DRAIN on flush_req.
REQ-024 SHALL move DRAIN -> DONE in the first cycle that the registered busy is 0.
REQ-025 SHALL leave DONE for IDLE unconditionally after one cycle.
REQ-026 SHALL drive rsv_ready = (state == IDLE) & ~flush_req.
REQ-027 SHALL keep releases and queries serviced in every state.
REQ-028 SHALL drive flush_done high only in DONE, as a one-cycle pulse.
REQ-029 SHALL ignore flush_req while in DRAIN or DONE.
REQ-030 SHALL, on a flush request with the scoreboard already empty, spend one DRAIN cycle and then one DONE cycle.
REQ-031 SHALL drive busy as the OR of all entries' registered state.

Reset
REQ-032 SHALL, on rst_n low and asynchronously:
  - clear all entries to 0;
  - set the FSM to IDLE;
  - drive flush_done = 0, busy = 0 and rsv_ready = 1.
REQ-033 SHALL, on reset during DRAIN, abort the flush with no flush_done pulse.

Configuration
REQ-034 SHALL, with SCOREBOARD_STATS_EN defined, add output stall_cnt, 32 bits.
REQ-035 SHALL increment stall_cnt each cycle that collision is high, saturating at 32'hFFFF_FFFF, and reset it to 0.
REQ-036 SHALL, without SCOREBOARD_STATS_EN, have no stall_cnt port and no counter logic.

Structure
REQ-037 SHALL place the flush FSM state enum (sb_flush_state_t) and the register index constants REG_CR = 32 and REG_PR = 33 in package scoreboard_pkg.
REQ-038 SHALL use one sub-module, scoreboard_mp_entry, holding a single TID's vector with set-mask and clear-mask inputs, generated NUM_TID times.

Verification
REQ-039 SHALL cover reserve then query:
  - reserve tid 5, map 0x3 (regs 0 and 1);
  - next cycle, query tid 5 with map 0x2 -> collision = 1;
  - query with map 0x4 -> collision = 0.
REQ-040 SHALL cover dual release:
  - entry 7 holds regs 3 and 9;
  - port 0 releases reg 3 and port 1 releases reg 9 for tid 7, same cycle;
  - entry 7 = 0 the next cycle; collision = 1 during the release cycle.
REQ-041 SHALL cover set wins:
  - reserve tid 2 with map bit 4, same cycle as a release of tid 2 reg 4;
  - bit 4 remains set.
REQ-042 SHALL cover flush drain:
  - entry 1 holds reg 0; pulse flush_req;
  - rsv_ready = 0 while waiting; release reg 0 at cycle 5;
  - busy = 0 at cycle 6; flush_done pulses at cycle 7; rsv_ready = 1 at cycle 8.
REQ-043 SHALL cover out-of-range release:
  - release with wb_reg = 40 -> no entry changes;
  - reset asserted mid-DRAIN -> FSM IDLE and no flush_done pulse.
REQ-044 SHALL cover statistics, with SCOREBOARD_STATS_EN defined:
  - hold collision high for 10 cycles -> stall_cnt = 10.
